dft_out_stage: RTL and testbench
================================

Name: dft_out_stage

Overview:
- Output post-processor between the DFT core's complex per-bin result and downstream consumers.
- Tags each result with its bin index and a frame-last flag.
- Applies runtime-selectable inverse normalisation: arithmetic shift by log2(N), with optional round-half-up.
- Buffers results in a small FIFO behind a valid/ready handshake, replacing the unbuffered, fixed-shift output register used so far.

Parameters:
- WIDTH, 12, signed sample width of real and imaginary parts.
- BIN_NUM, 32, bins per frame; bin counter wraps at BIN_NUM-1.
- N_MAX, 32, maximum transform length.
- LOG_N_MAX, $clog2(N_MAX), maximum normalisation shift.
- FIFO_DEPTH, 8, output FIFO entries; power of two, ≥2.

Ports:
- i_sys_clk  in  1  single clock; all logic on the rising edge.
- i_sys_rst  in  1  synchronous, active-low reset.
- i_X  in  2×WIDTH  signed complex bin result; [0]=re, [1]=im.
- i_valid  in  1  i_X valid this cycle; never back-pressured.
- i_inverse  in  1  1 = apply normalisation shift.
- i_log_n  in  $clog2(LOG_N_MAX+1)  shift amount; values above LOG_N_MAX are clamped to LOG_N_MAX.
- i_round  in  1  1 = round-half-up before shifting.
- i_clr_flags  in  1  clears o_overflow.
- i_ready  in  1  downstream ready.
- o_X  out  2×WIDTH  signed processed result.
- o_bin  out  $clog2(BIN_NUM)  bin index of o_X.
- o_last  out  1  o_bin == BIN_NUM-1.
- o_valid  out  1  o_X/o_bin/o_last valid.
- o_overflow  out  1  sticky: an input was dropped because the FIFO was full.

Behaviour:
- Reset (i_sys_rst==0 at a rising edge):
  - o_valid=0, o_overflow=0, o_X=0, o_bin=0, o_last=0.
  - FIFO empty, bin counter=0, FSM=S_IDLE, latched config cleared.
  - Reset mid-frame discards all buffered data; the next accepted input is bin 0.
- Frame FSM:
  - S_IDLE→S_FRAME on i_valid. On that edge, latch i_inverse, clamped i_log_n and i_round; the sample is bin 0.
  - S_FRAME: each i_valid increments the bin counter.
  - When the input tagged BIN_NUM-1 is taken, the counter wraps to 0 and the FSM returns to S_IDLE.
  - Config changes mid-frame are ignored until the next bin 0.
  - Config of the bin-0 input itself is taken from the same cycle.
- Arithmetic, per component, using a WIDTH+1-bit intermediate:
  - Latched inverse=0 or shift s=0: pass-through.
  - Inverse, no round: y = x >>> s (floor).
  - Inverse, round: y = (x + 2^(s-1)) >>> s.
  - Result always fits WIDTH bits; truncate to WIDTH. No saturation logic is required.
- Pipeline:
  - Stage 1 registers the processed data plus bin/last tag, then pushes into the FIFO.
  - FIFO is first-word-fall-through with a registered output.
  - Latency from i_valid to o_valid is 2 cycles when the FIFO is empty.
- Handshake:
  - A beat transfers when o_valid && i_ready.
  - o_X/o_bin/o_last are held stable while o_valid && !i_ready.
  - o_valid deasserts only after the last entry transfers.
- Full FIFO:
  - A push when full with no pop in the same cycle drops the sample and sets o_overflow.
  - The bin counter still advances, so tags stay frame-aligned.
  - Push and pop in the same cycle when full: both succeed.
- Empty FIFO:
  - Pop is ignored; o_valid=0.
  - A push into an empty FIFO appears on o_valid on the next cycle.
- o_overflow:
  - Cleared by i_clr_flags.
  - If set and clear occur in the same cycle, set wins.

Decomposition:
- Shared package dft_pkg:
  - localparams for widths derived from WIDTH/BIN_NUM/LOG_N_MAX.
  - typedef cplx_t (2×signed WIDTH).
  - typedef bin_tag_t {bin, last}.
  - FSM enum {S_IDLE, S_FRAME}.
- One sub-module: dft_out_fifo, a parametrised FWFT FIFO of {cplx_t, bin_tag_t} with full/empty and same-cycle push/pop.
- The scaling datapath stays inline.

Test Plan:
- Reset: hold i_sys_rst=0 for 3 cycles with i_valid=1 → o_valid=0, o_overflow=0, o_bin=0 throughout.
- Pass-through: inverse=0, i_ready=1, X=(100,-100) → 2 cycles later o_X=(100,-100), o_bin=0, o_valid=1 for one cycle.
- Inverse, no round, log_n=5: X=(1000,-1000) → (31,-32). Same input with round=1 → (31,-31).
- Wrap/last: 34 consecutive valids → o_last=1 only on o_bin=31, then o_bin=0,1. Change log_n at bin 10 → no effect until the next bin 0.
- Backpressure: i_ready=0, push 10 bins → o_overflow=1 after the 9th push. Raise i_ready → bins 0..7 drained in order. The next input is tagged bin 10.
- Mid-frame reset: reset after 5 bins with data queued → o_valid=0 after the reset edge. The next input emerges as o_bin=0.

Source files
------------

// File: rtl/dft_pkg.sv
// Shared widths, types and arithmetic helpers for the DFT output post-processor.
// Sizes live here so the top, the FIFO and the bench agree on one definition.
package dft_pkg;

    localparam int WIDTH      = 12;
    localparam int BIN_NUM    = 32;
    localparam int N_MAX      = 32;
    localparam int LOG_N_MAX  = $clog2(N_MAX);
    localparam int FIFO_DEPTH = 8;
    localparam int BIN_W      = $clog2(BIN_NUM);
    localparam int SHIFT_W    = $clog2(LOG_N_MAX + 1);

    // [0] = real, [1] = imaginary
    typedef logic [1:0][WIDTH-1:0] cplx_t;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic             last;
    } bin_tag_t;

    typedef struct packed {
        cplx_t    x;
        bin_tag_t tag;
    } fifo_word_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } frame_state_t;

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] v);
        return (v > SHIFT_W'(LOG_N_MAX)) ? SHIFT_W'(LOG_N_MAX) : v;
    endfunction

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [WIDTH-1:0] scale_sample(
        input logic [WIDTH-1:0]   x,
        input logic               inv,
        input logic               rnd,
        input logic [SHIFT_W-1:0] s
    );
        logic signed [WIDTH:0] t;
        logic signed [WIDTH:0] half;
        t    = $signed({x[WIDTH-1], x});
        half = '0;
        if (inv && (s != '0)) begin
            if (rnd) begin
                half = (WIDTH+1)'(1) << (s - SHIFT_W'(1));
                t    = t + half;
            end
            t = t >>> s;
        end
        return t[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/dft_out_fifo.sv
// First-word-fall-through FIFO with a registered head: the head register is one
// of the DEPTH entries, the memory holds the rest. Same-cycle push/pop when full is allowed.
module dft_out_fifo
    import dft_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic       clk_sys,
    input  logic       rst_b,
    input  logic       push,
    input  fifo_word_t din,
    input  logic       pop,
    output fifo_word_t dout,
    output logic       valid,
    output logic       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fifo_word_t      mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            pop_ok;
    logic            push_ok;
    logic            load_direct;
    logic            mem_we;
    logic            mem_re;

    assign valid       = (count != '0);
    assign full        = (count == CW'(DEPTH));
    assign pop_ok      = pop && valid;
    assign push_ok     = push && (!full || pop_ok);
    assign drop        = push && !push_ok;
    // Head slot is (or becomes) free and nothing waits in memory: load din straight into it.
    assign load_direct = !valid || (pop_ok && (count == CW'(1)));
    assign mem_we      = push_ok && !load_direct;
    assign mem_re      = pop_ok && !load_direct;

    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            count <= count + CW'(push_ok) - CW'(pop_ok);
            if (load_direct && push_ok) begin
                dout <= din;
            end else if (mem_re) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (mem_we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (mem_we) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/dft_out_stage.sv
// DFT output post-processor: bin/last tagging, runtime inverse normalisation,
// and a buffered valid/ready output through dft_out_fifo.
//
//   state   | meaning
//   S_IDLE  | waiting for bin 0; config is taken from the inputs of that cycle
//   S_FRAME | mid-frame; latched config applies, bin counter advances per i_valid
module dft_out_stage
    import dft_pkg::*;
(
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    input  cplx_t              i_X,
    input  logic               i_valid,
    input  logic               i_inverse,
    input  logic [SHIFT_W-1:0] i_log_n,
    input  logic               i_round,
    input  logic               i_clr_flags,
    input  logic               i_ready,
    output cplx_t              o_X,
    output logic [BIN_W-1:0]   o_bin,
    output logic               o_last,
    output logic               o_valid,
    output logic               o_overflow
);

    frame_state_t       state;
    logic [BIN_W-1:0]   bin_cnt;
    logic               cfg_inv;
    logic               cfg_rnd;
    logic [SHIFT_W-1:0] cfg_shift;

    logic               eff_inv;
    logic               eff_rnd;
    logic [SHIFT_W-1:0] eff_shift;
    logic [BIN_W-1:0]   cur_bin;
    logic               cur_last;

    logic               s1_valid;
    fifo_word_t         s1_word;
    fifo_word_t         head;
    logic               drop;

    always_comb begin
        eff_inv   = cfg_inv;
        eff_rnd   = cfg_rnd;
        eff_shift = cfg_shift;
        cur_bin   = bin_cnt;
        if (state == S_IDLE) begin
            eff_inv   = i_inverse;
            eff_rnd   = i_round;
            eff_shift = clamp_shift(i_log_n);
            cur_bin   = '0;
        end
        cur_last = (cur_bin == BIN_W'(BIN_NUM - 1));
    end

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst) begin
            state      <= S_IDLE;
            bin_cnt    <= '0;
            cfg_inv    <= 1'b0;
            cfg_rnd    <= 1'b0;
            cfg_shift  <= '0;
            s1_valid   <= 1'b0;
            s1_word    <= '0;
            o_overflow <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_word.x[0]     <= scale_sample(i_X[0], eff_inv, eff_rnd, eff_shift);
                s1_word.x[1]     <= scale_sample(i_X[1], eff_inv, eff_rnd, eff_shift);
                s1_word.tag.bin  <= cur_bin;
                s1_word.tag.last <= cur_last;
                if (state == S_IDLE) begin
                    cfg_inv   <= eff_inv;
                    cfg_rnd   <= eff_rnd;
                    cfg_shift <= eff_shift;
                end
                if (cur_last) begin
                    bin_cnt <= '0;
                    state   <= S_IDLE;
                end else begin
                    bin_cnt <= cur_bin + BIN_W'(1);
                    state   <= S_FRAME;
                end
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_flags) begin
                o_overflow <= 1'b0;
            end
        end
    end

    dft_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (i_sys_clk),
        .rst_b   (i_sys_rst),
        .push    (s1_valid),
        .din     (s1_word),
        .pop     (i_ready),
        .dout    (head),
        .valid   (o_valid),
        .drop    (drop)
    );

    assign o_X    = head.x;
    assign o_bin  = head.tag.bin;
    assign o_last = head.tag.last;

endmodule

// File: tb/tb_dft_out_stage.sv
// Scoreboard bench for dft_out_stage: expected beats are queued as stimulus is
// driven and compared when the DUT transfers them.
module tb_dft_out_stage;
    import dft_pkg::*;

    logic               i_sys_clk;
    logic               i_sys_rst;
    cplx_t              i_X;
    logic               i_valid;
    logic               i_inverse;
    logic [SHIFT_W-1:0] i_log_n;
    logic               i_round;
    logic               i_clr_flags;
    logic               i_ready;
    cplx_t              o_X;
    logic [BIN_W-1:0]   o_bin;
    logic               o_last;
    logic               o_valid;
    logic               o_overflow;

    dft_out_stage dut (
        .i_sys_clk   (i_sys_clk),
        .i_sys_rst   (i_sys_rst),
        .i_X         (i_X),
        .i_valid     (i_valid),
        .i_inverse   (i_inverse),
        .i_log_n     (i_log_n),
        .i_round     (i_round),
        .i_clr_flags (i_clr_flags),
        .i_ready     (i_ready),
        .o_X         (o_X),
        .o_bin       (o_bin),
        .o_last      (o_last),
        .o_valid     (o_valid),
        .o_overflow  (o_overflow)
    );

    initial begin
        i_sys_clk = 1'b0;
        forever #5 i_sys_clk = ~i_sys_clk;
    end

    typedef struct {
        int re;
        int im;
        int bin;
        int last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_bin    = 0;
    bit   m_inv    = 0;
    bit   m_rnd    = 0;
    int   m_shift  = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int model_scale(input int x, input bit inv, input int s, input bit rnd);
        int d;
        int v;
        if (!inv || s == 0) return x;
        d = 1 << s;
        v = rnd ? x + d / 2 : x;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic tick();
        @(posedge i_sys_clk);
        #1;
    endtask

    task automatic quiet(input int n);
        i_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input int re, input int im, input bit keep);
        exp_t e;
        i_X[0]  = WIDTH'(re);
        i_X[1]  = WIDTH'(im);
        i_valid = 1'b1;
        if (m_bin == 0) begin
            m_inv   = i_inverse;
            m_rnd   = i_round;
            m_shift = (int'(i_log_n) > 5) ? 5 : int'(i_log_n);
        end
        e.re   = model_scale(re, m_inv, m_shift, m_rnd);
        e.im   = model_scale(im, m_inv, m_shift, m_rnd);
        e.bin  = m_bin;
        e.last = (m_bin == 31) ? 1 : 0;
        if (keep) sb.push_back(e);
        m_bin = (m_bin + 1) % 32;
        tick();
    endtask

    task automatic do_reset(input int n);
        i_sys_rst = 1'b0;
        for (int k = 0; k < n; k++) tick();
        i_sys_rst = 1'b1;
        sb.delete();
        m_bin = 0;
    endtask

    // Scoreboard side: compare every transferred beat.
    always @(negedge i_sys_clk) begin
        if (i_sys_rst && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_beat", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_re",   int'($signed(o_X[0])), e.re);
                check("out_im",   int'($signed(o_X[1])), e.im);
                check("out_bin",  int'(o_bin), e.bin);
                check("out_last", int'(o_last), e.last);
            end
        end
    end

    initial begin
        int hold_re;
        i_sys_rst   = 1'b0;
        i_X         = '0;
        i_valid     = 1'b1;
        i_inverse   = 1'b0;
        i_log_n     = '0;
        i_round     = 1'b0;
        i_clr_flags = 1'b0;
        i_ready     = 1'b1;

        // Reset held 3 cycles with i_valid high
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_valid", int'(o_valid), 0);
            check("rst_ovf",   int'(o_overflow), 0);
            check("rst_bin",   int'(o_bin), 0);
        end
        check("rst_x_re", int'($signed(o_X[0])), 0);
        check("rst_last", int'(o_last), 0);
        i_valid   = 1'b0;
        i_sys_rst = 1'b1;
        tick();

        // Pass-through with 2-cycle latency and a single-cycle o_valid
        send(100, -100, 1);
        i_valid = 1'b0;
        check("lat_valid_c1", int'(o_valid), 0);
        tick();
        check("lat_valid_c2", int'(o_valid), 1);
        check("lat_re", int'($signed(o_X[0])), 100);
        check("lat_im", int'($signed(o_X[1])), -100);
        check("lat_bin", int'(o_bin), 0);
        tick();
        check("lat_valid_c3", int'(o_valid), 0);

        // Inverse, no round, log_n=5
        do_reset(1);
        i_inverse = 1'b1; i_log_n = 3'd5; i_round = 1'b0;
        send(1000, -1000, 1);
        quiet(1);
        check("inv_floor_re", int'($signed(o_X[0])), 31);
        check("inv_floor_im", int'($signed(o_X[1])), -32);
        quiet(2);

        // Inverse with round; log_n=7 clamps to 5
        do_reset(1);
        i_log_n = 3'd7; i_round = 1'b1;
        send(1000, -1000, 1);
        quiet(1);
        check("inv_round_re", int'($signed(o_X[0])), 31);
        check("inv_round_im", int'($signed(o_X[1])), -31);
        quiet(2);

        // Small shift, both rounding modes on negative/positive inputs
        do_reset(1);
        i_log_n = 3'd2; i_round = 1'b0;
        send(-5, 6, 1);
        quiet(3);
        do_reset(1);
        i_round = 1'b1;
        send(-5, 6, 1);
        quiet(3);

        // Frame wrap: 34 back-to-back bins, log_n changed at bin 10
        do_reset(1);
        i_inverse = 1'b1; i_log_n = 3'd1; i_round = 1'b0;
        for (int k = 0; k < 34; k++) begin
            if (k == 10) i_log_n = 3'd3;
            send(k * 37 - 600, 500 - k * 29, 1);
        end
        quiet(4);
        check("wrap_sb_empty", sb.size(), 0);

        // Backpressure: 10 pushes into an 8-entry FIFO
        do_reset(1);
        i_inverse = 1'b0; i_ready = 1'b0;
        for (int k = 0; k < 9; k++) send(k * 10 + 1, -k * 10 - 2, k < 8);
        check("ovf_before_drop", int'(o_overflow), 0);
        i_clr_flags = 1'b1;
        send(91, -92, 0);
        check("ovf_set_wins", int'(o_overflow), 1);
        quiet(1);
        check("ovf_set_wins2", int'(o_overflow), 1);
        check("hold_valid", int'(o_valid), 1);
        check("hold_bin", int'(o_bin), 0);
        hold_re = int'($signed(o_X[0]));
        check("hold_re", hold_re, 1);
        quiet(1);
        check("ovf_cleared", int'(o_overflow), 0);
        i_clr_flags = 1'b0;
        i_ready = 1'b1;
        quiet(10);
        check("drain_sb_empty", sb.size(), 0);
        send(333, -333, 1);
        quiet(3);

        // Full FIFO with push and pop on the same edge
        i_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(k + 200, -k - 200, 1);
        quiet(1);
        send(250, -250, 1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("full_pushpop_ovf", int'(o_overflow), 0);
        quiet(12);
        check("full_sb_empty", sb.size(), 0);

        // Mid-frame reset with data queued
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(k + 40, k - 40, 1);
        i_valid = 1'b0;
        do_reset(1);
        check("midrst_valid", int'(o_valid), 0);
        check("midrst_bin", int'(o_bin), 0);
        i_ready = 1'b1;
        i_inverse = 1'b0;
        send(7, 8, 1);
        quiet(4);
        check("midrst_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
